// File: rtl/bitu_ungrp_seq.sv
// bitu_ungrp_seq: iterative bit-ungroup (inverse of GRP).
// Mask-1 bits are taken in order from the low end of data_in, and mask-0 bits
// from index popcount(mask) upward. BITS_PER_CYCLE result bits are resolved
// per cycle.
// Optional build macro: BITU_UNGRP_FASTPATH_EN. When it is defined, masks of
// all-zeros or all-ones finish one cycle after accept.
module bitu_ungrp_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic [31:0] bitmask,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [31:0] dat_q, msk_q, acc_q, acc_d, res_q;
  logic [5:0]  lo_q, hi_q, pos_q, lo_d, hi_d, pos_d, pc;
  logic [4:0]  p;
  logic        rdy_q, vld_q;
  logic        fast_hit;

`ifdef BITU_UNGRP_FASTPATH_EN
  logic fast_q;
  assign fast_hit = fast_q;
`else
  assign fast_hit = 1'b0;
`endif

  // Popcount of the incoming mask; it seeds the zero-bit pointer at accept.
  always_comb begin
    pc = '0;
    for (int i = 0; i < 32; i++) pc = pc + {5'd0, bitmask[i]};
  end

  // Resolve one chunk of result positions. Each position consumes the next
  // bit from either the ones stream (lo) or the zeros stream (hi).
  // Only the pointer that is actually consumed is indexed, so its low 5 bits
  // are always in range.
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    p     = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      p = pos_q[4:0] + 5'(j);
      if (msk_q[p]) begin
        acc_d[p] = dat_q[lo_d[4:0]];
        lo_d     = lo_d + 6'd1;
      end else begin
        acc_d[p] = dat_q[hi_d[4:0]];
        hi_d     = hi_d + 6'd1;
      end
    end
    pos_d = pos_q + 6'(BITS_PER_CYCLE);
  end

  // Control FSM with registered handshake outputs. The result is copied to
  // data_out only on completion, so a kill leaves the previous result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      msk_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      pos_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
`ifdef BITU_UNGRP_FASTPATH_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && rdy_q) begin
            dat_q   <= data_in;
            msk_q   <= bitmask;
            acc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= pc;
            pos_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= BUSY;
`ifdef BITU_UNGRP_FASTPATH_EN
            fast_q  <= (bitmask == 32'h0000_0000) || (bitmask == 32'hFFFF_FFFF);
`endif
          end
        end
        BUSY: begin
          if (kill) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else if (fast_hit) begin
            res_q   <= dat_q;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            pos_q <= pos_d;
            if (pos_d == 6'd32) begin
              res_q   <= acc_d;
              vld_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign data_out  = res_q;

endmodule

// File: doc/bitu_ungrp_seq.md
Name: bitu_ungrp_seq

Overview:
- Iterative UNGRP unit. It is the inverse of the GRP bit-group operation.
- GRP packs mask=1 bits to the LSB end and mask=0 bits to the MSB end, order preserved. UNGRP scatters those bits back to their original positions.
- Sits beside the combinational GRP unit in the bit-manipulation path. Multi-cycle, with valid/ready handshakes on both sides.

Parameters:
- BITS_PER_CYCLE, 1, result bits produced per cycle; legal values 1, 2, 4, 8. Latency = 32/BITS_PER_CYCLE cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  unit can accept operands
- data_in  input  32  grouped data, as produced by GRP
- bitmask  input  32  mask used by the original GRP
- kill  input  1  abort the current operation; result discarded
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- data_out  output  32  ungrouped result

Behaviour:
- Function:
  - n = popcount(bitmask).
  - Scan result positions i = 0..31 in ascending order.
  - If bitmask[i]=1: data_out[i] = data_in[lo], then lo++. lo starts at 0.
  - Else: data_out[i] = data_in[hi], then hi++. hi starts at n.
  - For all data d and mask m: GRP(UNGRP(d,m),m) = d.
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, data_out=0.
  - All internal registers (pointers, position counter, operand copies) are cleared.
- States:
  - IDLE: in_ready=1. in_valid&&in_ready latches data_in and bitmask, loads lo=0 and hi=n (popcount computed combinationally at accept), loads pos=0, then goes to BUSY.
  - BUSY: in_ready=0. Each cycle resolves positions pos..pos+BITS_PER_CYCLE-1. Uses a prefix count of the latched mask within the chunk, then advances lo and hi by the chunk's one/zero counts and pos by BITS_PER_CYCLE. After the chunk containing position 31, go to DONE.
  - DONE: out_valid=1 and data_out stable. out_valid&&out_ready returns to IDLE.
- Pipelining: none. in_ready stays 0 in DONE, even in the cycle out_ready=1.
- Latency: accept at edge k gives out_valid=1 from edge k+32/BITS_PER_CYCLE.
- Pointer widths:
  - lo and hi are 6 bits; hi may reach 32 after the final chunk.
  - Indexing uses only values <32 for positions actually resolved.
  - n=32 leaves hi unused; n=0 leaves lo unused.
- kill:
  - In BUSY or DONE: next edge goes to IDLE, out_valid=0, data_out holds its last value.
  - In IDLE: ignored, and has no effect on a same-cycle accept.
  - kill takes priority over out_ready.
- data_out is stable from out_valid rise until the handshake. Partial results are never visible as valid.
- Operand changes on data_in/bitmask after accept have no effect.

Optional Feature:
- BITU_UNGRP_FASTPATH_EN
- Defined:
  - In IDLE, an accept with bitmask==32'h0000_0000 or bitmask==32'hFFFF_FFFF skips BUSY.
  - data_out is loaded with data_in and DONE is entered next edge: out_valid at k+1.
  - The result is identical to the slow path, since UNGRP is the identity for these masks.
- Undefined: every mask takes the full 32/BITS_PER_CYCLE cycles.

Test Plan:
- Rotation: bitmask=FFFF0000, data_in=1234ABCD, BITS_PER_CYCLE=1 -> out_valid at accept+32, data_out=ABCD1234.
- Interleave:
  - bitmask=AAAAAAAA, data_in=0000FFFF -> data_out=AAAAAAAA.
  - Then data_in=FFFF0000 -> data_out=55555555.
  - Repeat for BITS_PER_CYCLE=1,2,4,8 with latency 32/16/8/4.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> data_out constant, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- Kill/reset:
  - kill asserted 5 cycles into BUSY -> IDLE next edge, no out_valid. The next operand (mask 0000FFFF, data 89ABCDEF) returns 89ABCDEF.
  - rst_n low mid-BUSY -> outputs go to reset values immediately.
- Identity masks 00000000 and FFFFFFFF with data DEADBEEF -> data_out=DEADBEEF. Latency is 1 with BITU_UNGRP_FASTPATH_EN and 32/BITS_PER_CYCLE without it.
- Random round-trip: 10k random (d,m) pairs -> GRP reference model applied to data_out equals d.
